// File: rtl/alu_pkg.sv
// Shared types and default sizes for the structural ALU front end.
// The state encoding is fixed at two bits so the downstream logic can decode it.
package alu_pkg;

  localparam int DEF_WIDTH = 4;
  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    ISSUE  = 2'd2
  } state_t;

endpackage

// File: rtl/alu_operand_loader.sv
// Collects operand A, then operand B plus a select bit, from a valid/ready beat stream.
// It then offers the pair to the ALU operand mux behind an output valid/ready handshake.
module alu_operand_loader
  import alu_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_sel,
  output logic [WIDTH-1:0] d0,
  output logic [WIDTH-1:0] d1,
  output logic             s,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] pair_cnt
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_reg;
  logic [WIDTH-1:0] d0_reg;
  logic [WIDTH-1:0] d1_reg;
  logic             s_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic in_ready_int;
  logic beat;
  logic handoff;

  // While a pair is held, a new A beat can only enter if the held pair leaves on the same edge.
  assign in_ready_int = rst_n && !flush && ((state_reg != ISSUE) || out_ready);
  assign beat         = in_valid && in_ready_int;
  assign handoff      = (state_reg == ISSUE) && out_ready && rst_n && !flush;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= LOAD_A;
      d0_reg    <= '0;
      d1_reg    <= '0;
      s_reg     <= 1'b0;
      cnt_reg   <= '0;
    end else if (flush) begin
      // Operand registers keep their values; only the sequencing is abandoned.
      state_reg <= LOAD_A;
    end else begin
      case (state_reg)
        LOAD_A: begin
          if (beat) begin
            d0_reg    <= in_data;
            state_reg <= LOAD_B;
          end
        end
        LOAD_B: begin
          if (beat) begin
            d1_reg    <= in_data;
            s_reg     <= in_sel;
            state_reg <= ISSUE;
          end
        end
        ISSUE: begin
          if (handoff) begin
            cnt_reg <= cnt_reg + CNT_ONE;
            if (beat) begin
              d0_reg    <= in_data;
              state_reg <= LOAD_B;
            end else begin
              state_reg <= LOAD_A;
            end
          end
        end
        default: state_reg <= LOAD_A;
      endcase
    end
  end

  assign in_ready  = in_ready_int;
  assign out_valid = (state_reg == ISSUE);
  assign d0        = d0_reg;
  assign d1        = d1_reg;
  assign s         = s_reg;
  assign pair_cnt  = cnt_reg;

endmodule

// File: tb/tb_alu_operand_loader.sv
// Directed and randomized check of alu_operand_loader against a beat-queue reference model.
// One line is printed per pair handed off to the consumer.
module tb_alu_operand_loader;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic [WIDTH-1:0] d0;
  logic [WIDTH-1:0] d1;
  logic             s;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] pair_cnt;

  alu_operand_loader #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_sel(in_sel),
    .d0(d0), .d1(d1), .s(s), .out_valid(out_valid), .out_ready(out_ready),
    .pair_cnt(pair_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: beats accepted toward the current pair, plus last captured values.
  logic [WIDTH:0] pend_q[$];
  logic [WIDTH-1:0] m_d0, m_d1;
  logic             m_s;
  int               m_cnt;
  int               m_pairs;
  bit               m_known = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare against the model, then advance the model on the edge.
  task automatic step(input logic r, input logic f, input logic iv, input logic [WIDTH-1:0] dat,
                      input logic sel, input logic ordy);
    bit exp_ready, exp_valid, acc, take;
    rst_n = r; flush = f; in_valid = iv; in_data = dat; in_sel = sel; out_ready = ordy;
    #1;
    exp_valid = (pend_q.size() == 2);
    exp_ready = r && !f && (!exp_valid || ordy);
    if (m_known || !r) check("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
    if (m_known) begin
      check("out_valid", {31'b0, out_valid}, {31'b0, exp_valid});
      check("d0", {28'b0, d0}, {28'b0, m_d0});
      check("d1", {28'b0, d1}, {28'b0, m_d1});
      check("s", {31'b0, s}, {31'b0, m_s});
      check("pair_cnt", {24'b0, pair_cnt}, m_cnt);
    end
    @(posedge clk);
    acc  = iv && exp_ready;
    take = exp_valid && ordy && r && !f;
    if (!r) begin
      pend_q.delete();
      m_d0 = '0; m_d1 = '0; m_s = 1'b0; m_cnt = 0; m_known = 1;
    end else if (f) begin
      pend_q.delete();
    end else begin
      if (take) begin
        m_pairs++;
        $display("pair %0d: d0=%h d1=%h s=%b cnt->%0d", m_pairs, m_d0, m_d1, m_s, (m_cnt + 1) % 256);
        pend_q.delete();
        m_cnt = (m_cnt + 1) % 256;
      end
      if (acc) begin
        if (pend_q.size() == 0) m_d0 = dat;
        else begin m_d1 = dat; m_s = sel; end
        pend_q.push_back({sel, dat});
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(1'b0, 1'b0, 1'b1, 4'hF, 1'b1, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_sel = 1'b0; out_ready = 1'b0;
    m_d0 = '0; m_d1 = '0; m_s = 1'b0; m_cnt = 0; m_pairs = 0;
    @(negedge clk);

    // Reset held two cycles with in_valid asserted
    do_reset();
    do_reset();
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_pair_cnt", {24'b0, pair_cnt}, 32'd0);
    check("rst_d0", {28'b0, d0}, 32'd0);

    // Basic pair
    step(1'b1, 1'b0, 1'b1, 4'h3, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 4'hA, 1'b1, 1'b1);
    check("basic_valid", {31'b0, out_valid}, 32'd1);
    check("basic_d0", {28'b0, d0}, 32'h3);
    check("basic_d1", {28'b0, d1}, 32'hA);
    check("basic_s", {31'b0, s}, 32'd1);
    step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    check("basic_valid_drop", {31'b0, out_valid}, 32'd0);
    check("basic_cnt", {24'b0, pair_cnt}, 32'd1);

    // Backpressure, then handoff with a simultaneous A beat
    do_reset();
    step(1'b1, 1'b0, 1'b1, 4'h5, 1'b0, 1'b1);
    step(1'b1, 1'b0, 1'b1, 4'h6, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, 1'b1, 4'hF, 1'b1, 1'b0);
      check("bp_d0", {28'b0, d0}, 32'h5);
      check("bp_d1", {28'b0, d1}, 32'h6);
    end
    step(1'b1, 1'b0, 1'b1, 4'h7, 1'b0, 1'b1);
    check("bp_new_d0", {28'b0, d0}, 32'h7);
    check("bp_cnt", {24'b0, pair_cnt}, 32'd1);
    check("bp_loadb", {31'b0, out_valid}, 32'd0);
    step(1'b1, 1'b0, 1'b1, 4'h8, 1'b1, 1'b0);
    check("bp_pair2", {31'b0, out_valid}, 32'd1);

    // Streaming: 8 beats back to back
    do_reset();
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b1, 4'(i + 1), i[1], 1'b1);
    step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    check("stream_cnt", {24'b0, pair_cnt}, 32'd4);

    // Flush in LOAD_B and in ISSUE
    do_reset();
    step(1'b1, 1'b0, 1'b1, 4'h9, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 4'h4, 1'b1, 1'b0);
    check("flush_d0", {28'b0, d0}, 32'h9);
    step(1'b1, 1'b0, 1'b1, 4'h1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b1, 4'h2, 1'b1, 1'b0);
    check("flush_issue_valid", {31'b0, out_valid}, 32'd1);
    step(1'b1, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1);
    check("flush_issue_cnt", {24'b0, pair_cnt}, 32'd0);
    check("flush_issue_drop", {31'b0, out_valid}, 32'd0);

    // Counter wrap: 256 pairs back to 0, 257th gives 1
    do_reset();
    for (int i = 0; i < 514; i++) begin
      step(1'b1, 1'b0, 1'b1, 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), 1'b1);
      if (i == 511) check("wrap_255", {24'b0, pair_cnt}, 32'd255);
      if (i == 512) check("wrap_0", {24'b0, pair_cnt}, 32'd0);
    end
    step(1'b1, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1);
    check("wrap_1", {24'b0, pair_cnt}, 32'd1);

    // Randomized traffic with occasional flush and reset
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 63) != 0), ($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) != 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
